// File: rtl/button_debouncer.sv
// Push-button debouncer: turns a synchronized, bouncy button level into a clean
// debounced level plus one-cycle press / release strobes and a one-shot long-press strobe.
// Ports: clk, rst (async active-low), in_sync (already in clk domain) ->
//        level, press, release_o, long_press (all registered).
// Latency: level/press/release_o follow STABLE_CYCLES consecutive identical samples; no backpressure.
module button_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int LONG_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_sync,
  output logic level,
  output logic press,
  // "release" is a reserved word in SystemVerilog, hence the suffix.
  output logic release_o,
  output logic long_press
);

  localparam int MAX_CYCLES = (STABLE_CYCLES > LONG_CYCLES) ? STABLE_CYCLES : LONG_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;    // consecutive-sample qualification counter
  logic [CNT_W-1:0] hold_q,  hold_d;   // cycles spent high since press acceptance
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q,   rel_d;
  logic             long_q,  long_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;

    unique case (state_q)
      S_LOW: begin
        if (in_sync) begin
          state_d = S_RISE;
          cnt_d   = CNT_ONE;   // this edge already counts as the first high sample
        end else begin
          cnt_d   = '0;
        end
      end

      S_RISE: begin
        if (!in_sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_M1) begin
          state_d = S_HIGH;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
          hold_d  = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      S_HIGH: begin
        if (!in_sync) begin
          state_d = S_FALL;
          cnt_d   = CNT_ONE;
        end else if (hold_q != LONG_MAX) begin
          // Saturating at LONG_CYCLES makes the long-press strobe one-shot.
          hold_d = hold_q + CNT_ONE;
          long_d = (hold_q == LONG_M1);
        end
      end

      S_FALL: begin
        // hold_q is frozen here so a glitch neither resets nor re-arms long press.
        if (in_sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_M1) begin
          state_d = S_LOW;
          level_d = 1'b0;
          rel_d   = 1'b1;
          cnt_d   = '0;
          hold_d  = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        hold_d  = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level      = level_q;
  assign press      = press_q;
  assign release_o  = rel_q;
  assign long_press = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, LONG_CYCLES=16.
// Outputs are checked 1 time unit after each rising edge as {level, press, release, long_press}.
// Inputs change at the same point, well away from the sampling edge.
module tb_button_debouncer;

  logic clk;
  logic rst;
  logic in_sync;
  logic level;
  logic press;
  logic release_o;
  logic long_press;

  int n_assert = 0;
  int n_fail   = 0;

  button_debouncer #(
    .STABLE_CYCLES(4),
    .LONG_CYCLES  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_sync   (in_sync),
    .level     (level),
    .press     (press),
    .release_o (release_o),
    .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {level, press, release_o, long_press};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed lvl/prs/rel/long=%b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive in_sync, then for n edges check the outputs against exp.
  task automatic run(input logic in, input logic [3:0] exp, input int n, input string tag);
    in_sync = in;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk(tag, exp);
    end
  endtask

  initial begin
    rst     = 1'b0;
    in_sync = 1'b1;

    // Reset held with the button pressed: nothing may leak out.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", 4'b0000);
    end
    rst = 1'b1;

    // Press needs four fresh high samples after reset release.
    run(1'b1, 4'b0000, 3, "rst_qualify");
    run(1'b1, 4'b1100, 1, "rst_press");
    // Long press: fires 16 edges after press, once only (40 cycles held in total).
    run(1'b1, 4'b1000, 15, "long_wait");
    run(1'b1, 4'b1001, 1, "long_fire");
    run(1'b1, 4'b1000, 24, "long_no_repeat");
    // Clean release.
    run(1'b0, 4'b1000, 3, "rel_qualify");
    run(1'b0, 4'b0010, 1, "rel_strobe");
    run(1'b0, 4'b0000, 2, "rel_idle");

    // Clean press from idle.
    run(1'b1, 4'b0000, 3, "clean_qualify");
    run(1'b1, 4'b1100, 1, "clean_press");
    run(1'b1, 4'b1000, 1, "clean_level");

    // Release glitch 0,0,1: level stays, no release.
    run(1'b0, 4'b1000, 2, "glitch_low");
    run(1'b1, 4'b1000, 2, "glitch_back");
    run(1'b0, 4'b1000, 3, "glitch_rel_qualify");
    run(1'b0, 4'b0010, 1, "glitch_rel_strobe");
    run(1'b0, 4'b0000, 1, "glitch_rel_idle");

    // Bounce 1,1,1,0 six times: never accepted.
    for (int r = 0; r < 6; r++) begin
      run(1'b1, 4'b0000, 3, "bounce_high");
      run(1'b0, 4'b0000, 1, "bounce_low");
    end
    run(1'b1, 4'b0000, 3, "bounce_qualify");
    run(1'b1, 4'b1100, 1, "bounce_press");
    run(1'b1, 4'b1000, 1, "bounce_level");

    // Asynchronous reset while level is high clears outputs with no clock edge.
    rst = 1'b0;
    #2;
    chk("async_clr_high", 4'b0000);
    #2;
    rst = 1'b1;
    run(1'b1, 4'b0000, 3, "post_rst_qualify");
    run(1'b1, 4'b1100, 1, "post_rst_press");
    run(1'b0, 4'b1000, 3, "post_rst_rel_qualify");
    run(1'b0, 4'b0010, 1, "post_rst_rel");
    run(1'b0, 4'b0000, 1, "post_rst_idle");

    // Reset mid-qualification discards the two high samples already taken.
    run(1'b1, 4'b0000, 2, "midq_partial");
    rst = 1'b0;
    #2;
    chk("midq_async_clr", 4'b0000);
    rst = 1'b1;
    run(1'b1, 4'b0000, 3, "midq_requalify");
    run(1'b1, 4'b1100, 1, "midq_press");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
